// File: rtl/sparc_pkg.sv
// -----------------------------------------------------------------------------
// sparc_pkg
// Shared definitions for the SPARC V8 windowed register file:
//   - win_op_e    : window operation encodings carried on win_op
//   - trap_type_e : trap cause encodings reported on trap_type
//   - register region offsets inside a 24-register window view
// -----------------------------------------------------------------------------
package sparc_pkg;

    typedef enum logic [1:0] {
        WOP_NOP      = 2'b00,
        WOP_SAVE     = 2'b01,
        WOP_RESTORE  = 2'b10,
        WOP_LOAD_CWP = 2'b11
    } win_op_e;

    typedef enum logic [1:0] {
        TRAP_NONE      = 2'b00,
        TRAP_OVERFLOW  = 2'b01,
        TRAP_UNDERFLOW = 2'b10,
        TRAP_BAD_CWP   = 2'b11
    } trap_type_e;

    // Offsets of the outs/locals/ins groups relative to a window's base.
    localparam int OUTS          = 0;
    localparam int LOCALS        = 8;
    localparam int INS           = 16;
    // Distance between consecutive window bases; smaller than the 24-entry
    // view, which is what makes ins of window w alias outs of window w+1.
    localparam int WINDOW_STRIDE = 16;

endpackage

// File: rtl/windowed_register_file_if.sv
// -----------------------------------------------------------------------------
// windowed_register_file_if
// Bundles the register file's read/write ports and window-control signals.
//   slave  : the register file (consumes addresses/ops, drives data/status)
//   master : the datapath/control side driving it
// -----------------------------------------------------------------------------
interface windowed_register_file_if #(
    parameter int NWINDOWS = 8,
    parameter int WIDTH    = 32
) ();
    logic [4:0]          in_PA;
    logic [4:0]          in_PB;
    logic [4:0]          in_PC;
    logic                wr_en;
    logic [WIDTH-1:0]    wr_data;
    logic [WIDTH-1:0]    out_PA;
    logic [WIDTH-1:0]    out_PB;
    logic [1:0]          win_op;
    logic [4:0]          cwp_in;
    logic                wim_we;
    logic [NWINDOWS-1:0] wim_in;
    logic [4:0]          cwp;
    logic [NWINDOWS-1:0] wim;
    logic                trap_valid;
    logic [1:0]          trap_type;

    modport slave (
        input  in_PA, in_PB, in_PC, wr_en, wr_data, win_op, cwp_in, wim_we, wim_in,
        output out_PA, out_PB, cwp, wim, trap_valid, trap_type
    );

    modport master (
        output in_PA, in_PB, in_PC, wr_en, wr_data, win_op, cwp_in, wim_we, wim_in,
        input  out_PA, out_PB, cwp, wim, trap_valid, trap_type
    );
endinterface

// File: rtl/window_addr_map.sv
// -----------------------------------------------------------------------------
// window_addr_map
// Combinational translation of an architectural register number (r0..r31)
// in a given window to a physical storage index.
//   arch_addr : architectural register number
//   window    : window the access decodes in (must be < NWINDOWS)
//   phys_idx  : index into storage; 0..7 are r0..r7 (globals), windowed
//               entries start at 8 and wrap modulo 16*NWINDOWS.
// -----------------------------------------------------------------------------
module window_addr_map
    import sparc_pkg::*;
#(
    parameter int  NWINDOWS = 8,
    localparam int PW       = $clog2(8 + WINDOW_STRIDE * NWINDOWS)
) (
    input  logic [4:0]    arch_addr,
    input  logic [4:0]    window,
    output logic [PW-1:0] phys_idx
);
    localparam logic [PW-1:0] RING         = PW'(WINDOW_STRIDE * NWINDOWS);
    localparam logic [PW-1:0] GLOBAL_SLOTS = PW'(8);

    logic [PW-1:0] region_off;
    logic [PW-1:0] sum;
    logic [PW-1:0] rel;

    // NOTE: every signal assigned in this block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        region_off = PW'(INS);
        case (arch_addr[4:3])
            2'b01:   region_off = PW'(OUTS);
            2'b10:   region_off = PW'(LOCALS);
            default: region_off = PW'(INS);
        endcase
        // window < NWINDOWS and offset < 24, so the sum is below 2*RING and a
        // single conditional subtract performs the modulo.
        sum = PW'(window) * PW'(WINDOW_STRIDE) + region_off + PW'(arch_addr[2:0]);
        rel = (sum >= RING) ? sum - RING : sum;
        phys_idx = (arch_addr[4:3] == 2'b00) ? PW'(arch_addr) : rel + GLOBAL_SLOTS;
    end

endmodule

// File: rtl/windowed_register_file.sv
// -----------------------------------------------------------------------------
// windowed_register_file
// SPARC V8 windowed integer register file: 7 globals plus NWINDOWS
// overlapping 16-register window slices, with CWP/WIM ownership and
// SAVE/RESTORE/LOAD_CWP execution including trap detection.
//   Clk  : clock, rising edge
//   Clr  : asynchronous active-high clear of CWP, WIM and trap outputs
//   bus  : slave side of windowed_register_file_if
//          two combinational read ports (in_PA/out_PA, in_PB/out_PB),
//          one write port (in_PC, wr_en, wr_data), window control
//          (win_op, cwp_in, wim_we, wim_in), status (cwp, wim,
//          trap_valid, trap_type).
// -----------------------------------------------------------------------------
module windowed_register_file
    import sparc_pkg::*;
#(
    parameter int NWINDOWS = 8,
    parameter int WIDTH    = 32
) (
    input  logic                      Clk,
    input  logic                      Clr,
    windowed_register_file_if.slave   bus
);
    localparam int         PHYS_DEPTH = 8 + WINDOW_STRIDE * NWINDOWS;
    localparam int         PW         = $clog2(PHYS_DEPTH);
    localparam int         WW         = (NWINDOWS > 1) ? $clog2(NWINDOWS) : 1;
    localparam logic [5:0] NWIN6      = 6'(NWINDOWS);
    localparam logic [4:0] LAST_WIN   = 5'(NWINDOWS - 1);

    logic [4:0]          cwp_q, cwp_d;
    logic [NWINDOWS-1:0] wim_q, wim_d;
    logic                trap_valid_q, trap_valid_d;
    trap_type_e          trap_type_q, trap_type_d;

    logic [WIDTH-1:0]    regs [PHYS_DEPTH];

    win_op_e             op;
    logic [4:0]          target;
    logic                wr_fire;
    logic [PW-1:0]       pa_idx, pb_idx, pc_idx;

    assign op = win_op_e'(bus.win_op);

    // Window control: the trap check always looks at the old WIM, so a WIM
    // load in the same cycle only affects later operations.
    always_comb begin
        cwp_d        = cwp_q;
        wim_d        = bus.wim_we ? bus.wim_in : wim_q;
        trap_valid_d = 1'b0;
        trap_type_d  = TRAP_NONE;
        target       = cwp_q;
        case (op)
            WOP_SAVE: begin
                target = (cwp_q == 5'd0) ? LAST_WIN : cwp_q - 5'd1;
                if (wim_q[target[WW-1:0]]) begin
                    trap_valid_d = 1'b1;
                    trap_type_d  = TRAP_OVERFLOW;
                end else begin
                    cwp_d = target;
                end
            end
            WOP_RESTORE: begin
                target = (cwp_q == LAST_WIN) ? 5'd0 : cwp_q + 5'd1;
                if (wim_q[target[WW-1:0]]) begin
                    trap_valid_d = 1'b1;
                    trap_type_d  = TRAP_UNDERFLOW;
                end else begin
                    cwp_d = target;
                end
            end
            WOP_LOAD_CWP: begin
                if ({1'b0, bus.cwp_in} < NWIN6) begin
                    cwp_d = bus.cwp_in;
                end else begin
                    trap_valid_d = 1'b1;
                    trap_type_d  = TRAP_BAD_CWP;
                end
            end
            default: ;
        endcase
    end

    // A trapping op kills the write; r0 is never stored.
    assign wr_fire = bus.wr_en && !trap_valid_d && (bus.in_PC != 5'd0);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            cwp_q        <= '0;
            wim_q        <= '0;
            trap_valid_q <= 1'b0;
            trap_type_q  <= TRAP_NONE;
        end else begin
            cwp_q        <= cwp_d;
            wim_q        <= wim_d;
            trap_valid_q <= trap_valid_d;
            trap_type_q  <= trap_type_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; it maps onto plain
    // RAM/flop arrays, and r0 is forced to zero at the read mux instead.
    // Sampling Clr here drops a write that lands on the edge Clr releases.
    always_ff @(posedge Clk) begin
        if (wr_fire && !Clr) begin
            regs[pc_idx] <= bus.wr_data;
        end
    end

    // Reads decode with the registered CWP; the write decodes with the
    // post-op CWP so SAVE/RESTORE write rd in the new window.
    window_addr_map #(.NWINDOWS(NWINDOWS)) u_map_pa (
        .arch_addr (bus.in_PA),
        .window    (cwp_q),
        .phys_idx  (pa_idx)
    );

    window_addr_map #(.NWINDOWS(NWINDOWS)) u_map_pb (
        .arch_addr (bus.in_PB),
        .window    (cwp_q),
        .phys_idx  (pb_idx)
    );

    window_addr_map #(.NWINDOWS(NWINDOWS)) u_map_pc (
        .arch_addr (bus.in_PC),
        .window    (cwp_d),
        .phys_idx  (pc_idx)
    );

    assign bus.out_PA     = (bus.in_PA == 5'd0) ? '0 : regs[pa_idx];
    assign bus.out_PB     = (bus.in_PB == 5'd0) ? '0 : regs[pb_idx];
    assign bus.cwp        = cwp_q;
    assign bus.wim        = wim_q;
    assign bus.trap_valid = trap_valid_q;
    assign bus.trap_type  = trap_type_q;

endmodule

// File: tb/tb_windowed_register_file.sv
// -----------------------------------------------------------------------------
// tb_windowed_register_file
// Directed bench for windowed_register_file with an 8-window and a 2-window
// instance sharing clock and clear. Expected values are queued as each
// stimulus step is driven and popped when the result is observed.
// -----------------------------------------------------------------------------
module tb_windowed_register_file;
    import sparc_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    windowed_register_file_if #(.NWINDOWS(8), .WIDTH(32)) b8 ();
    windowed_register_file_if #(.NWINDOWS(2), .WIDTH(32)) b2 ();

    windowed_register_file #(.NWINDOWS(8), .WIDTH(32)) u8 (
        .Clk (clk),
        .Clr (clr),
        .bus (b8)
    );

    windowed_register_file #(.NWINDOWS(2), .WIDTH(32)) u2 (
        .Clk (clk),
        .Clr (clr),
        .bus (b2)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic expect_val(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv8(input logic [1:0] op, input logic we,
                        input logic [4:0] rd, input logic [31:0] d);
        b8.win_op  = op;
        b8.wr_en   = we;
        b8.in_PC   = rd;
        b8.wr_data = d;
        b8.wim_we  = 1'b0;
    endtask

    task automatic drv2(input logic [1:0] op, input logic we,
                        input logic [4:0] rd, input logic [31:0] d);
        b2.win_op  = op;
        b2.wr_en   = we;
        b2.in_PC   = rd;
        b2.wr_data = d;
        b2.wim_we  = 1'b0;
    endtask

    initial begin
        drv8(WOP_NOP, 1'b0, 5'd0, 32'h0);
        drv2(WOP_NOP, 1'b0, 5'd0, 32'h0);
        b8.in_PA = 5'd0; b8.in_PB = 5'd0; b8.cwp_in = 5'd0; b8.wim_in = 8'h00;
        b2.in_PA = 5'd0; b2.in_PB = 5'd0; b2.cwp_in = 5'd0; b2.wim_in = 2'b00;

        // ---- reset state ----
        #1 clr = 1'b1;
        #1;
        expect_val("rst_cwp", 32'd0);        check(32'(b8.cwp));
        expect_val("rst_wim", 32'd0);        check(32'(b8.wim));
        expect_val("rst_trap_valid", 32'd0); check(32'(b8.trap_valid));
        expect_val("rst_trap_type", 32'd0);  check(32'(b8.trap_type));
        tick();
        clr = 1'b0;

        // ---- r0 is hardwired zero ----
        drv8(WOP_NOP, 1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        drv8(WOP_NOP, 1'b0, 5'd0, 32'h0);
        b8.in_PA = 5'd0;
        #1;
        expect_val("r0_reads_zero", 32'h0);  check(b8.out_PA);

        // ---- writes in window 0 ----
        drv8(WOP_NOP, 1'b1, 5'd3,  32'h1234_5678); tick();
        drv8(WOP_NOP, 1'b1, 5'd8,  32'hDEAD_BEEF); tick();
        drv8(WOP_NOP, 1'b1, 5'd16, 32'hCAFE_F00D); tick();
        drv8(WOP_NOP, 1'b1, 5'd9,  32'h0000_0001); tick();

        // ---- same-cycle read returns old value (no bypass) ----
        drv8(WOP_NOP, 1'b1, 5'd9, 32'h0000_0002);
        b8.in_PA = 5'd9; b8.in_PB = 5'd3;
        #1;
        expect_val("no_bypass_old", 32'h1); check(b8.out_PA);
        tick();
        drv8(WOP_NOP, 1'b0, 5'd0, 32'h0);
        #1;
        expect_val("write_latency_new", 32'h2);       check(b8.out_PA);
        expect_val("global_r3_w0", 32'h1234_5678);    check(b8.out_PB);

        // ---- SAVE: globals persist, outs of w0 become ins of w7 ----
        drv8(WOP_SAVE, 1'b0, 5'd0, 32'h0);
        tick();
        drv8(WOP_NOP, 1'b0, 5'd0, 32'h0);
        b8.in_PA = 5'd3; b8.in_PB = 5'd24;
        #1;
        expect_val("save_cwp", 32'd7);                check(32'(b8.cwp));
        expect_val("global_r3_w7", 32'h1234_5678);    check(b8.out_PA);
        expect_val("overlap_r24_w7", 32'hDEAD_BEEF);  check(b8.out_PB);

        // ---- RESTORE with write lands in the new window ----
        drv8(WOP_RESTORE, 1'b1, 5'd17, 32'h0000_0077);
        tick();
        drv8(WOP_NOP, 1'b0, 5'd0, 32'h0);
        b8.in_PA = 5'd8; b8.in_PB = 5'd17;
        #1;
        expect_val("restore_cwp", 32'd0);             check(32'(b8.cwp));
        expect_val("restore_r8_w0", 32'hDEAD_BEEF);   check(b8.out_PA);
        expect_val("restore_wr_new_win", 32'h77);     check(b8.out_PB);

        // ---- window overflow ----
        b8.wim_we = 1'b1; b8.wim_in = 8'h80;
        tick();
        b8.wim_we = 1'b0;
        expect_val("wim_load", 32'h80);               check(32'(b8.wim));
        drv8(WOP_SAVE, 1'b1, 5'd16, 32'h0000_0BAD);
        tick();
        drv8(WOP_NOP, 1'b0, 5'd0, 32'h0);
        b8.in_PA = 5'd16;
        #1;
        expect_val("ovf_trap_valid", 32'd1);          check(32'(b8.trap_valid));
        expect_val("ovf_trap_type", 32'(TRAP_OVERFLOW)); check(32'(b8.trap_type));
        expect_val("ovf_cwp_kept", 32'd0);            check(32'(b8.cwp));
        expect_val("ovf_write_killed", 32'hCAFE_F00D); check(b8.out_PA);
        tick();
        expect_val("ovf_pulse_end_valid", 32'd0);     check(32'(b8.trap_valid));
        expect_val("ovf_pulse_end_type", 32'd0);      check(32'(b8.trap_type));

        // ---- WIM load in the same cycle as SAVE: old WIM decides ----
        drv8(WOP_SAVE, 1'b0, 5'd0, 32'h0);
        b8.wim_we = 1'b1; b8.wim_in = 8'h00;
        tick();
        drv8(WOP_NOP, 1'b0, 5'd0, 32'h0);
        expect_val("old_wim_trap_valid", 32'd1);      check(32'(b8.trap_valid));
        expect_val("old_wim_cwp_kept", 32'd0);        check(32'(b8.cwp));
        expect_val("new_wim_applied", 32'h00);        check(32'(b8.wim));

        // ---- window underflow from cwp 7 ----
        drv8(WOP_LOAD_CWP, 1'b0, 5'd0, 32'h0);
        b8.cwp_in = 5'd7;
        tick();
        expect_val("load_cwp7", 32'd7);               check(32'(b8.cwp));
        drv8(WOP_NOP, 1'b1, 5'd16, 32'h0000_5555); tick();
        drv8(WOP_NOP, 1'b0, 5'd0, 32'h0);
        b8.wim_we = 1'b1; b8.wim_in = 8'h01;
        tick();
        drv8(WOP_RESTORE, 1'b1, 5'd16, 32'h0000_0BAD);
        tick();
        drv8(WOP_NOP, 1'b0, 5'd0, 32'h0);
        b8.in_PA = 5'd16;
        #1;
        expect_val("unf_trap_valid", 32'd1);          check(32'(b8.trap_valid));
        expect_val("unf_trap_type", 32'(TRAP_UNDERFLOW)); check(32'(b8.trap_type));
        expect_val("unf_cwp_kept", 32'd7);            check(32'(b8.cwp));
        expect_val("unf_write_killed", 32'h5555);     check(b8.out_PA);

        // ---- LOAD_CWP out of range, then in range with write ----
        drv8(WOP_LOAD_CWP, 1'b1, 5'd20, 32'h0000_0EEE);
        b8.cwp_in = 5'd9;
        tick();
        expect_val("bad_cwp_trap_type", 32'(TRAP_BAD_CWP)); check(32'(b8.trap_type));
        expect_val("bad_cwp_kept", 32'd7);            check(32'(b8.cwp));
        drv8(WOP_LOAD_CWP, 1'b1, 5'd20, 32'h0000_0ABC);
        b8.cwp_in = 5'd5;
        tick();
        drv8(WOP_NOP, 1'b0, 5'd0, 32'h0);
        b8.in_PA = 5'd20;
        #1;
        expect_val("load_cwp5", 32'd5);               check(32'(b8.cwp));
        expect_val("load_cwp_wr_new_win", 32'hABC);   check(b8.out_PA);
        expect_val("load_cwp_no_trap", 32'd0);        check(32'(b8.trap_valid));

        // ---- asynchronous clear between edges ----
        #2 clr = 1'b1;
        #1;
        expect_val("async_clr_cwp", 32'd0);           check(32'(b8.cwp));
        expect_val("async_clr_wim", 32'd0);           check(32'(b8.wim));
        @(negedge clk);
        clr = 1'b0;
        tick();

        // ---- 2-window build: wrap and ring aliasing ----
        drv2(WOP_NOP, 1'b1, 5'd8, 32'h0000_2222); tick();
        drv2(WOP_SAVE, 1'b0, 5'd0, 32'h0);
        tick();
        drv2(WOP_NOP, 1'b0, 5'd0, 32'h0);
        b2.in_PA = 5'd24;
        #1;
        expect_val("n2_save_cwp1", 32'd1);            check(32'(b2.cwp));
        expect_val("n2_ins_w1_alias", 32'h2222);      check(b2.out_PA);
        drv2(WOP_SAVE, 1'b0, 5'd0, 32'h0);
        tick();
        expect_val("n2_save_wrap_cwp0", 32'd0);       check(32'(b2.cwp));
        drv2(WOP_RESTORE, 1'b0, 5'd0, 32'h0);
        tick();
        expect_val("n2_restore_cwp1", 32'd1);         check(32'(b2.cwp));
        drv2(WOP_NOP, 1'b1, 5'd8, 32'h0000_3333); tick();
        drv2(WOP_LOAD_CWP, 1'b0, 5'd0, 32'h0);
        b2.cwp_in = 5'd0;
        tick();
        drv2(WOP_NOP, 1'b0, 5'd0, 32'h0);
        b2.in_PA = 5'd24;
        #1;
        expect_val("n2_ins_w0_alias", 32'h3333);      check(b2.out_PA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
